// File: rtl/priory_encoder.sv
// priory_encoder: 4-input priority encoder with registered outputs.
// x[4] has the highest priority and x[1] the lowest. pcode is the index of the
// highest set bit of x, valid is the OR of x, and both appear one cycle after x
// is sampled.
// Optional feature macro PRIORY_ENCODER_ONEHOT_EN adds the registered one-hot
// grant[4:1] port. It marks the winning request bit.
module priory_encoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:1] x,
`ifdef PRIORY_ENCODER_ONEHOT_EN
   output logic [4:1] grant,
`endif
   output logic [2:0] pcode,
   output logic       valid
);

   logic [2:0] pcode_d;
   logic [2:0] pcode_q;
   logic       valid_d;
   logic       valid_q;

   // Priority decode. Every branch assigns a code, including the all-zero
   // default, so this logic cannot infer a latch. Codes 3'b101..3'b111 cannot
   // be produced.
   always_comb begin
      pcode_d = 3'b000;
      if (x[4]) begin
         pcode_d = 3'b100;
      end else if (x[3]) begin
         pcode_d = 3'b011;
      end else if (x[2]) begin
         pcode_d = 3'b010;
      end else if (x[1]) begin
         pcode_d = 3'b001;
      end
      valid_d = |x;
   end

   // Output registers. Reset clears them asynchronously, and the first rising
   // edge after release loads the code for the current x.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcode_q <= 3'b000;
         valid_q <= 1'b0;
      end else begin
         pcode_q <= pcode_d;
         valid_q <= valid_d;
      end
   end

   assign pcode = pcode_q;
   assign valid = valid_q;

`ifdef PRIORY_ENCODER_ONEHOT_EN
   logic [4:1] grant_d;
   logic [4:1] grant_q;

   // One-hot winner. A bit wins when it is set and no higher bit is set.
   // The top bit has nothing above it.
   always_comb begin
      grant_d    = 4'b0000;
      grant_d[4] = x[4];
      grant_d[3] = x[3] & ~x[4];
      grant_d[2] = x[2] & ~(|x[4:3]);
      grant_d[1] = x[1] & ~(|x[4:2]);
   end

   // Grant register. It shares the reset behaviour of pcode and valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q <= 4'b0000;
      end else begin
         grant_q <= grant_d;
      end
   end

   assign grant = grant_q;
`endif

endmodule

// File: tb/tb_priory_encoder.sv
// tb_priory_encoder: directed vectors with hand-computed expectations for
// priory_encoder. Checks on grant run only when PRIORY_ENCODER_ONEHOT_EN is defined.
module tb_priory_encoder;

   logic       clk;
   logic       rst_n;
   logic [4:1] x;
   logic [2:0] pcode;
   logic       valid;
`ifdef PRIORY_ENCODER_ONEHOT_EN
   logic [4:1] grant;
`endif

   int vectors;
   int miscompares;

   // Expected code for x = 0..15, written out by hand.
   logic [2:0] exp_code [16];

   priory_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
`ifdef PRIORY_ENCODER_ONEHOT_EN
      .grant (grant),
`endif
      .pcode (pcode),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive x on the falling edge, then sample 1 ns after the next rising edge.
   task automatic apply(input logic [4:1] v);
      @(negedge clk);
      x = v;
      @(posedge clk);
      #1;
      $display("x=%b -> pcode=%b valid=%b", v, pcode, valid);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_code[0]  = 3'b000; exp_code[1]  = 3'b001;
      exp_code[2]  = 3'b010; exp_code[3]  = 3'b010;
      exp_code[4]  = 3'b011; exp_code[5]  = 3'b011;
      exp_code[6]  = 3'b011; exp_code[7]  = 3'b011;
      for (int i = 8; i < 16; i++) exp_code[i] = 3'b100;

      // Outputs must hold their reset values while reset is asserted, even with requests and clocks present.
      rst_n = 1'b0;
      x     = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_pcode", {5'd0, pcode}, 8'h00);
      check_val("reset_valid", {7'd0, valid}, 8'h00);
`ifdef PRIORY_ENCODER_ONEHOT_EN
      check_val("reset_grant", {4'd0, grant}, 8'h00);
`endif
      // Release reset. The first edge after release loads the code for 1111.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("release_pcode", {5'd0, pcode}, 8'h04);
      check_val("release_valid", {7'd0, valid}, 8'h01);

      // Exhaustive sweep of x, one value per cycle.
      for (int i = 0; i < 16; i++) begin
         apply(i[3:0]);
         check_val($sformatf("sweep_pcode_%0d", i), {5'd0, pcode}, {5'd0, exp_code[i]});
         check_val($sformatf("sweep_valid_%0d", i), {7'd0, valid}, (i == 0) ? 8'h00 : 8'h01);
      end

      // Lower-priority request bits are ignored when a higher bit is set.
      apply(4'b1111); check_val("prio_1111", {5'd0, pcode}, 8'h04);
      apply(4'b0111); check_val("prio_0111", {5'd0, pcode}, 8'h03);
      apply(4'b0011); check_val("prio_0011", {5'd0, pcode}, 8'h02);

      // Reset asserted between edges must clear the outputs without any clock edge.
      apply(4'b1000);
      check_val("pre_rst_pcode", {5'd0, pcode}, 8'h04);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_pcode", {5'd0, pcode}, 8'h00);
      check_val("async_valid", {7'd0, valid}, 8'h00);
`ifdef PRIORY_ENCODER_ONEHOT_EN
      check_val("async_grant", {4'd0, grant}, 8'h00);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("post_rst_pcode", {5'd0, pcode}, 8'h04);

      // A code registered before reset must not reappear once reset is released.
      @(negedge clk);
      rst_n = 1'b0;
      x     = 4'b0001;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("discard_pcode", {5'd0, pcode}, 8'h01);

      // A change of x mid-cycle has no effect until the next rising edge.
      apply(4'b0010);
      check_val("lat_before", {5'd0, pcode}, 8'h02);
      #2;
      x = 4'b0100;
      #1;
      check_val("lat_hold", {5'd0, pcode}, 8'h02);
      @(posedge clk);
      #1;
      check_val("lat_after", {5'd0, pcode}, 8'h03);

`ifdef PRIORY_ENCODER_ONEHOT_EN
      apply(4'b1010); check_val("grant_1010", {4'd0, grant}, 8'h08);
      apply(4'b0011); check_val("grant_0011", {4'd0, grant}, 8'h02);
      apply(4'b0110); check_val("grant_0110", {4'd0, grant}, 8'h04);
      apply(4'b0000); check_val("grant_0000", {4'd0, grant}, 8'h00);
`endif

      // x=0 followed by x=1 in consecutive cycles.
      apply(4'b0000);
      check_val("zero_pcode", {5'd0, pcode}, 8'h00);
      check_val("zero_valid", {7'd0, valid}, 8'h00);
      apply(4'b0001);
      check_val("one_pcode", {5'd0, pcode}, 8'h01);
      check_val("one_valid", {7'd0, valid}, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/priory_encoder.md
PRIORY_ENCODER -- requirements
Module: priory_encoder

Interface
REQ-001 Parameter: none; input width fixed at 4, code width fixed at 3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 x  input  [4:1]  request vector; bit 4 highest priority, bit 1 lowest.
REQ-005 pcode  output  [2:0]  registered priority code, i.e. the index of the highest set bit of x.
REQ-006 valid  output  1  registered; 1 when at least one bit of x was set.
REQ-007 grant  output  [4:1]  registered one-hot of the winning bit; present only when PRIORY_ENCODER_ONEHOT_EN is defined.

Function
REQ-008 Combinational code from x SHALL be as follows:
- x[4]=1 -> 3'b100
- else x[3]=1 -> 3'b011
- else x[2]=1 -> 3'b010
- else x[1]=1 -> 3'b001
- else 3'b000
REQ-009 Lower-priority bits SHALL be ignored whenever a higher bit is set (e.g. x=4'b1111 -> 3'b100; x=4'b0111 -> 3'b011).
REQ-010 pcode, valid and grant SHALL be registered, with 1-cycle latency: they reflect x sampled at the most recent rising clk edge.
REQ-011 valid SHALL equal OR-reduction of sampled x; x=4'b0000 gives pcode=3'b000, valid=0.
REQ-012 pcode=3'b000 with valid=0 SHALL be the only "no request" indication; codes 3'b101..3'b111 SHALL never be produced.
REQ-013 x SHALL be sampled every cycle with no handshake or enable; a change of x between edges SHALL have no effect until the next edge.
REQ-014 Outputs SHALL hold their value while x is stable; no glitches on the registered outputs.
REQ-015 The combinational x -> register path SHALL contain no latches; every code assignment SHALL be fully specified, including the all-zero default.

Reset
REQ-016 Assertion of rst_n=0 SHALL immediately (asynchronously) force pcode=3'b000, valid=0 and grant=4'b0000.
REQ-017 While rst_n=0, outputs SHALL stay at reset values regardless of x and clk.
REQ-018 Deassertion SHALL be sampled synchronously; the first rising edge with rst_n=1 loads the code for the current x.
REQ-019 Reset mid-operation SHALL discard the registered code; no previous value SHALL reappear after release.

Configuration
REQ-020 Macro PRIORY_ENCODER_ONEHOT_EN defined: port grant[4:1] exists and carries the one-hot winning bit (x=4'b0110 -> grant=4'b0100; x=0 -> grant=0).
REQ-021 Macro PRIORY_ENCODER_ONEHOT_EN undefined: port grant and its register are absent; pcode/valid behaviour is identical.

Verification
REQ-022 Exhaustive sweep: x from 4'b0000 to 4'b1111, one value per cycle -> pcode one cycle later matches:
- 0000 -> 000
- 0001 -> 001
- 001x -> 010
- 01xx -> 011
- 1xxx -> 100
REQ-023 x=4'b0000 -> pcode=3'b000, valid=0; x=4'b0001 next cycle -> pcode=3'b001, valid=1.
REQ-024 Priority check: x=4'b1111 -> pcode=3'b100; x=4'b0111 -> 3'b011; x=4'b0011 -> 3'b010.
REQ-025 Async reset: with x=4'b1000 and pcode=3'b100, pulse rst_n low between edges -> outputs 0 immediately without a clock edge; first edge after release -> pcode=3'b100.
REQ-026 Latency check: change x mid-cycle from 4'b0010 to 4'b0100 -> pcode stays 3'b010 until the next rising edge, then 3'b011.
REQ-027 With PRIORY_ENCODER_ONEHOT_EN defined: x=4'b1010 -> grant=4'b1000; x=4'b0011 -> grant=4'b0010; x=4'b0000 -> grant=4'b0000.
